// File: rtl/des_spi_controller_if.sv
// des_spi_controller_if: byte-stream and DES-core signals of the SPI-DES command sequencer
interface des_spi_controller_if #(parameter int BYTES = 8);
  localparam int W = 8 * BYTES;
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [W-1:0] key_out;
  logic [W-1:0] data_out;
  logic des_start;
  logic des_done;
  logic [W-1:0] des_result;
  logic busy;
  logic err;
  modport master (
    input rx_data, rx_valid, tx_ready, des_done, des_result,
    output rx_ready, tx_data, tx_valid, key_out, data_out, des_start, busy, err
  );
  modport slave (
    output rx_data, rx_valid, tx_ready, des_done, des_result,
    input rx_ready, tx_data, tx_valid, key_out, data_out, des_start, busy, err
  );
endinterface

// File: rtl/des_spi_controller.sv
// des_spi_controller: decodes SPI command bytes, loads key/data, runs the DES core and streams the result out
module des_spi_controller #(
  parameter int BYTES = 8,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  des_spi_controller_if.master bus
);
  localparam int W = 8 * BYTES;
  localparam int CW = $clog2(BYTES) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD_KEY, LOAD_DATA, RUN, READ} state_t;
  state_t state;
  logic [W-1:0] staging, key, data, result, tx_shift, shifted;
  logic key_loaded, data_loaded, result_valid;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic rx_fire, tx_fire, last;
  assign rx_fire = bus.rx_valid && bus.rx_ready;
  assign tx_fire = bus.tx_valid && bus.tx_ready;
  assign last = cnt == CW'(BYTES - 1);
  assign shifted = W'({staging, bus.rx_data});
  assign bus.key_out = key;
  assign bus.data_out = data;
  assign bus.busy = state != IDLE;
  // RUN covers both the start cycle and the wait for done; tcnt counts cycles since start
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      staging <= '0;
      key <= '0;
      data <= '0;
      result <= '0;
      tx_shift <= '0;
      key_loaded <= 1'b0;
      data_loaded <= 1'b0;
      result_valid <= 1'b0;
      cnt <= '0;
      tcnt <= '0;
      bus.rx_ready <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data <= '0;
      bus.des_start <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.des_start <= 1'b0;
      bus.err <= 1'b0;
      case (state)
        IDLE: begin
          bus.rx_ready <= 1'b1;
          if (rx_fire) begin
            cnt <= '0;
            case (bus.rx_data)
              8'h01: state <= LOAD_KEY;
              8'h02: state <= LOAD_DATA;
              8'h03: if (key_loaded && data_loaded) begin
                state <= RUN;
                bus.des_start <= 1'b1;
                bus.rx_ready <= 1'b0;
                tcnt <= '0;
              end else bus.err <= 1'b1;
              8'h04: if (result_valid) begin
                state <= READ;
                bus.rx_ready <= 1'b0;
                bus.tx_valid <= 1'b1;
                bus.tx_data <= result[W-1 -: 8];
                tx_shift <= result << 8;
              end else bus.err <= 1'b1;
              default: bus.err <= 1'b1;
            endcase
          end
        end
        LOAD_KEY, LOAD_DATA: if (rx_fire) begin
          staging <= shifted;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            if (state == LOAD_KEY) begin
              key <= shifted;
              key_loaded <= 1'b1;
            end else begin
              data <= shifted;
              data_loaded <= 1'b1;
            end
            result_valid <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: if (bus.des_done) begin
          result <= bus.des_result;
          result_valid <= 1'b1;
          state <= IDLE;
          bus.rx_ready <= 1'b1;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          bus.err <= 1'b1;
          state <= IDLE;
          bus.rx_ready <= 1'b1;
        end else tcnt <= tcnt + 1'b1;
        READ: if (tx_fire) begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) begin
            bus.tx_valid <= 1'b0;
            bus.rx_ready <= 1'b1;
            state <= IDLE;
          end else begin
            bus.tx_data <= tx_shift[W-1 -: 8];
            tx_shift <= tx_shift << 8;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_des_spi_controller.sv
// tb_des_spi_controller: directed and randomized checks of the SPI-DES sequencer against a word-level model
module tb_des_spi_controller;
  localparam int TIMEOUT = 255;
  logic clk, rst;
  des_spi_controller_if #(.BYTES(8)) bus();
  des_spi_controller #(.BYTES(8), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  int total = 0, bad = 0;
  int cyc = 0, start_cnt = 0, err_cnt = 0, start_cyc = -100000, err_cyc = 0, done_delay = 0;
  logic [63:0] m_key, m_data, m_result;
  bit m_key_ok, m_data_ok, m_res_ok;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc++;
    if (bus.des_start) begin start_cnt++; start_cyc = cyc; end
    if (bus.err) begin err_cnt++; err_cyc = cyc; end
    bus.des_done = done_delay > 0 && cyc == start_cyc + done_delay;
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b0; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0; done_delay = 0;
    tick(); tick();
    chk("rst_rx_ready", 64'(bus.rx_ready), 0);
    chk("rst_key", bus.key_out, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_busy", 64'(bus.busy), 0);
    m_key = 0; m_data = 0; m_result = 0; m_key_ok = 0; m_data_ok = 0; m_res_ok = 0;
    rst = 1'b1;
    tick();
    chk("rx_ready_after_rst", 64'(bus.rx_ready), 1);
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    bus.rx_data = b; bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 400) begin tick(); n++; end
    chk("rx_ready_wait", 64'(bus.rx_ready), 1);
    tick();
    bus.rx_valid = 1'b0;
  endtask
  task automatic err_check(input string tag);
    chk(tag, 64'(bus.err), 1);
    chk("no_start_on_err", 64'(bus.des_start), 0);
    tick();
    chk("err_one_cycle", 64'(bus.err), 0);
    chk("err_idle", 64'(bus.busy), 0);
  endtask
  task automatic load(input logic [7:0] op, input logic [63:0] w);
    logic [63:0] prev;
    prev = op == 8'h01 ? m_key : m_data;
    send(op);
    for (int i = 0; i < 8; i++) begin
      send(8'(w >> (56 - 8 * i)));
      if (i < 7) chk(op == 8'h01 ? "partial_key" : "partial_data", op == 8'h01 ? bus.key_out : bus.data_out, prev);
    end
    if (op == 8'h01) begin m_key = w; m_key_ok = 1; end else begin m_data = w; m_data_ok = 1; end
    m_res_ok = 0;
    chk("key_out", bus.key_out, m_key);
    chk("data_out", bus.data_out, m_data);
    chk("load_busy", 64'(bus.busy), 0);
  endtask
  task automatic run(input int delay);
    int s0, e0, n;
    s0 = start_cnt; e0 = err_cnt; n = 0;
    done_delay = delay;
    send(8'h03);
    if (!(m_key_ok && m_data_ok)) begin
      err_check("run_not_loaded_err");
      chk("no_start_count", 64'(start_cnt - s0), 0);
    end else begin
      chk("des_start", 64'(bus.des_start), 1);
      chk("busy_run", 64'(bus.busy), 1);
      tick();
      chk("des_start_width", 64'(bus.des_start), 0);
      while (bus.busy && n < 400) begin tick(); n++; end
      chk("run_back_idle", 64'(bus.busy), 0);
      chk("start_count", 64'(start_cnt - s0), 1);
      if (delay > 0 && delay < TIMEOUT) begin
        chk("run_no_err", 64'(err_cnt - e0), 0);
        m_res_ok = 1; m_result = bus.des_result;
      end else begin
        chk("timeout_err", 64'(err_cnt - e0), 1);
        chk("timeout_cycles", 64'(err_cyc - start_cyc), 64'(TIMEOUT));
      end
    end
    done_delay = 0;
  endtask
  task automatic read(input int mode);
    int pat[4] = '{1, 0, 0, 1};
    int n, k, rdy;
    bit stalled;
    logic [7:0] held;
    send(8'h04);
    if (!m_res_ok) begin
      err_check("read_no_result_err");
    end else begin
      chk("tx_valid_first", 64'(bus.tx_valid), 1);
      n = 0; k = 0; stalled = 0; held = 0;
      while (k < 8 && n < 200) begin
        rdy = mode == 0 ? 1 : mode == 1 ? pat[n % 4] : int'($urandom_range(0, 1));
        bus.tx_ready = rdy != 0;
        if (stalled) chk("tx_stall_hold", 64'(bus.tx_data), 64'(held));
        if (bus.tx_valid && rdy != 0) begin
          chk("tx_byte", 64'(bus.tx_data), 64'(8'(m_result >> (56 - 8 * k))));
          k++; stalled = 0;
        end else if (bus.tx_valid) begin
          stalled = 1; held = bus.tx_data;
        end
        tick(); n++;
      end
      bus.tx_ready = 1'b0;
      chk("tx_count", 64'(k), 8);
      chk("tx_valid_end", 64'(bus.tx_valid), 0);
      chk("read_idle", 64'(bus.busy), 0);
    end
  endtask
  initial begin
    rst = 1'b0; bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0; bus.des_result = '0;
    tick(); tick();
    chk("rst_tx_valid", 64'(bus.tx_valid), 0);
    chk("rst_tx_data", 64'(bus.tx_data), 0);
    chk("rst_des_start", 64'(bus.des_start), 0);
    chk("rst_err", 64'(bus.err), 0);
    do_reset();
    load(8'h01, 64'h0123456789ABCDEF);
    load(8'h02, 64'h1122334455667788);
    bus.des_result = 64'h85E813540F0AB405;
    run(10);
    read(0);
    read(1);
    do_reset();
    load(8'h01, 64'h0123456789ABCDEF);
    run(10);
    read(0);
    send(8'h7F);
    err_check("bad_cmd_err");
    load(8'h02, 64'hFEDCBA9876543210);
    run(0);
    read(0);
    bus.des_result = 64'hA5A55A5A0F0FF0F0;
    run(TIMEOUT - 1);
    read(1);
    send(8'h01);
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    do_reset();
    load(8'h01, 64'h0011223344556677);
    load(8'h02, 64'h8899AABBCCDDEEFF);
    run(3);
    read(0);
    load(8'h02, 64'h0102030405060708);
    read(0);
    for (int r = 0; r < 4; r++) begin
      load(8'h01, {$urandom, $urandom});
      load(8'h02, {$urandom, $urandom});
      bus.des_result = {$urandom, $urandom};
      run(int'($urandom_range(1, 20)));
      read(2);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
